// File: rtl/wb_ph_adc.sv
// Wishbone slave for the pH probe front end: drives an MCP3201-style 12-bit SPI ADC,
// keeps the last raw sample and a block average of 2**AVG_LOG2 samples.
module wb_ph_adc #(
    parameter int CLK_DIV  = 25,
    parameter int AVG_LOG2 = 4,
    parameter int GAP      = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_miso,
    output logic        irq
);
    localparam int ACCW = 12 + AVG_LOG2;
    localparam int IDXW = AVG_LOG2 + 1;
    localparam int CW   = 16;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAPW} state_t;
    state_t state, next_state;

    logic [CW-1:0]   cnt;
    logic [4:0]      half;
    logic            tick, commit, block_done, busy;
    logic            miso_s1, miso_s2;
    logic [15:0]     frame;
    logic [11:0]     sample, data_r, avg_r;
    logic            cont, svalid, avalid, ovr;
    logic [31:0]     conv_cnt, rdata;
    logic [ACCW-1:0] acc, acc_sum;
    logic [IDXW-1:0] idx;
    logic            req, wr_ctrl, start_go, rd_data_q, rd_avg_q;
    logic            unused;

    // Handshake: a request is stb & cyc while ack is low; ack follows one cycle later for
    // exactly one cycle; read side effects (clearing SVALID/AVALID/OVR) land at the end of ack.
    assign req      = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_ctrl  = req & wb_we_i & (wb_adr_i[4:2] == 3'd0);
    assign start_go = wr_ctrl & wb_dat_i[1];

    assign tick       = (state == GAPW) ? (cnt == CW'(GAP - 1)) : (cnt == CW'(CLK_DIV - 1));
    assign commit     = (state == HOLD) & tick;
    assign sample     = frame[12:1];
    assign acc_sum    = acc + ACCW'(sample);
    assign block_done = commit & (idx == IDXW'((1 << AVG_LOG2) - 1));
    assign busy       = (state != IDLE);
    assign irq        = avalid;
    assign unused     = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:2], frame[15]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_go || cont) next_state = SETUP;
            SETUP:   if (tick) next_state = SHIFT;
            SHIFT:   if (tick && half == 5'd31) next_state = HOLD;
            HOLD:    if (tick) next_state = cont ? GAPW : IDLE;
            GAPW:    if (tick) next_state = cont ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // SPI timing: one counter paces SETUP, each SCLK half-period, HOLD and the gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            half     <= '0;
            adc_sclk <= 1'b0;
            adc_cs_n <= 1'b1;
            frame    <= '0;
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
        end else begin
            miso_s1 <= adc_miso;
            miso_s2 <= miso_s1;
            if (tick || state != next_state || state == IDLE) cnt <= '0;
            else                                               cnt <= cnt + 1'b1;
            if (next_state == SETUP && state != SETUP) adc_cs_n <= 1'b0;
            else if (commit)                           adc_cs_n <= 1'b1;
            if (state == SHIFT && tick) begin
                adc_sclk <= ~adc_sclk;
                half     <= half + 1'b1;
                if (!adc_sclk) frame <= {frame[14:0], miso_s2};
            end else if (state != SHIFT) begin
                adc_sclk <= 1'b0;
                half     <= '0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i[4:2])
            3'd0:    rdata = {31'd0, cont};
            3'd1:    rdata = {28'd0, ovr, avalid, svalid, busy};
            3'd2:    rdata = {20'd0, data_r};
            3'd3:    rdata = {20'd0, avg_r};
            3'd4:    rdata = conv_cnt;
            default: rdata = '0;
        endcase
    end

    // Flags use set-wins priority when a commit coincides with the clearing read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            cont      <= 1'b0;
            rd_data_q <= 1'b0;
            rd_avg_q  <= 1'b0;
            svalid    <= 1'b0;
            avalid    <= 1'b0;
            ovr       <= 1'b0;
            data_r    <= '0;
            avg_r     <= '0;
            conv_cnt  <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            wb_ack_o  <= req;
            if (req) wb_dat_o <= rdata;
            if (wr_ctrl) cont <= wb_dat_i[0];
            rd_data_q <= req & ~wb_we_i & (wb_adr_i[4:2] == 3'd2);
            rd_avg_q  <= req & ~wb_we_i & (wb_adr_i[4:2] == 3'd3);
            svalid    <= commit | (svalid & ~rd_data_q);
            avalid    <= block_done | (avalid & ~rd_avg_q);
            ovr       <= (block_done & avalid) | (ovr & ~rd_avg_q);
            if (commit) begin
                data_r   <= sample;
                conv_cnt <= conv_cnt + 32'd1;
                if (block_done) begin
                    avg_r <= 12'(acc_sum >> AVG_LOG2);
                    acc   <= '0;
                    idx   <= '0;
                end else begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_ph_adc.sv
// Testbench for wb_ph_adc with a behavioural MCP3201 ADC and a register-level reference model.
module tb_wb_ph_adc;
    localparam int CLK_DIV  = 25;
    localparam int AVG_LOG2 = 4;
    localparam int GAP      = 100;
    localparam int BLK      = 1 << AVG_LOG2;
    localparam logic [31:0] A_CTRL = 32'h0, A_STAT = 32'h4, A_DATA = 32'h8;
    localparam logic [31:0] A_AVG  = 32'hC, A_CNT  = 32'h10;

    logic        clk, reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic        adc_cs_n, adc_sclk, adc_miso, irq;

    wb_ph_adc #(.CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2), .GAP(GAP)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_miso(adc_miso), .irq(irq)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_cnt;
    logic [11:0] m_data, m_avg;
    bit          m_svalid, m_avalid, m_ovr;
    int          blk_q[$];
    logic [11:0] exp_q[$];
    logic [11:0] feed_q[$];

    // ADC / bus monitor state
    logic [15:0] tx_frame = '0;
    logic [11:0] cur_s;
    int          bit_i = 16;
    int          rises = 0;
    int          cyc = 0, rise_c = 0, high_cyc = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_cnt = 0; m_data = '0; m_avg = '0;
        m_svalid = 0; m_avalid = 0; m_ovr = 0;
        blk_q.delete();
    endfunction

    function automatic void model_commit(input logic [11:0] s);
        int sum;
        m_cnt++;
        m_data   = s;
        m_svalid = 1;
        blk_q.push_back(int'(s));
        if (blk_q.size() == BLK) begin
            sum = 0;
            foreach (blk_q[i]) sum += blk_q[i];
            if (m_avalid) m_ovr = 1;
            m_avalid = 1;
            m_avg    = 12'(sum / BLK);
            blk_q.delete();
        end
    endfunction

    function automatic logic [31:0] exp_stat(input bit busy);
        return {28'd0, m_ovr, m_avalid, m_svalid, busy};
    endfunction

    always @(posedge clk) cyc++;

    // ADC: a frame is 3 junk bits, the 12-bit sample, 1 trailing junk bit, MSB first
    always @(negedge clk) begin
        if (cs_prev && !adc_cs_n) begin
            cur_s = (feed_q.size() > 0) ? feed_q.pop_front() : 12'($urandom_range(0, 4095));
            exp_q.push_back(cur_s);
            tx_frame = {3'($urandom_range(0, 7)), cur_s, 1'($urandom_range(0, 1))};
            bit_i = 0;
        end
        if (!sclk_prev && adc_sclk) begin
            rises++;
            rise_c = cyc;
        end
        if (sclk_prev && !adc_sclk) begin
            high_cyc = cyc - rise_c;
            bit_i++;
        end
        if (!cs_prev && adc_cs_n && exp_q.size() > 0) begin
            cur_s = exp_q.pop_front();
            if (bit_i == 16 && !reset) model_commit(cur_s);
        end
        cs_prev   = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    assign adc_miso = (bit_i < 16) ? tx_frame[15 - bit_i] : 1'b0;

    // driver tasks
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        @(posedge clk); #1;
        wb_adr_i = adr; wb_dat_i = wdat; wb_we_i = we;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) check("wb_ack_timeout", 32'(wb_ack_o), 32'd1);
        rdat = wb_dat_o;
        @(posedge clk); #1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        check("wb_ack_one_cycle", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'd0, rdat);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_commits(input int n, input int budget);
        int c = 0;
        while (m_cnt < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (m_cnt < n) check("commit_timeout", 32'(m_cnt), 32'(n));
    endtask

    task automatic wait_rises(input int n, input int budget);
        int c = 0;
        while (rises < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (rises < n) check("sclk_timeout", 32'(rises), 32'(n));
    endtask

    initial begin
        logic [31:0] rd;
        logic [11:0] s;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        reset = 1'b0;
        #2;
        do_reset();

        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        wb_read(A_STAT, rd); check("rst_stat", rd, 32'd0);
        wb_read(A_DATA, rd); check("rst_data", rd, 32'd0);
        wb_read(A_AVG, rd);  check("rst_avg", rd, 32'd0);
        wb_read(A_CNT, rd);  check("rst_cnt", rd, 32'd0);

        // one-shot conversion of 0xABC
        feed_q.push_back(12'hABC);
        rises = 0;
        wb_write(A_CTRL, 32'h2);
        wait_commits(1, 3000);
        repeat (5) @(posedge clk);
        #1;
        check("oneshot_rises", 32'(rises), 32'd16);
        check("oneshot_half_period", 32'(high_cyc), 32'(CLK_DIV));
        check("oneshot_cs_n", 32'(adc_cs_n), 32'd1);
        wb_read(A_STAT, rd); check("oneshot_stat", rd, 32'h2);
        wb_read(A_DATA, rd); check("oneshot_data", rd, 32'hABC);
        m_svalid = 0;
        wb_read(A_STAT, rd); check("oneshot_stat_after_data", rd, exp_stat(0));
        wb_read(A_CNT, rd);  check("oneshot_cnt", rd, 32'd1);
        wb_read(A_CTRL, rd); check("ctrl_start_reads_0", rd, 32'd0);

        // START while busy is ignored
        s = 12'($urandom_range(0, 4095));
        feed_q.push_back(s);
        rises = 0;
        wb_write(A_CTRL, 32'h2);
        wait_rises(3, 2000);
        wb_read(A_STAT, rd); check("busy_stat", rd, exp_stat(1));
        wb_write(A_CTRL, 32'h2);
        wait_commits(2, 3000);
        repeat (GAP + 200) @(posedge clk);
        #1;
        check("busy_start_rises", 32'(rises), 32'd16);
        wb_read(A_CNT, rd);  check("busy_start_cnt", rd, 32'd2);
        wb_read(A_DATA, rd); check("busy_start_data", rd, {20'd0, s});
        m_svalid = 0;

        // reset in the middle of SHIFT aborts at once
        wb_write(A_CTRL, 32'h1);
        wait_rises(rises + 5, 2000);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_cs_n", 32'(adc_cs_n), 32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd0);
        do_reset();
        wb_read(A_CNT, rd);  check("abort_cnt", rd, 32'd0);
        wb_read(A_STAT, rd); check("abort_stat", rd, 32'd0);
        wb_read(A_CTRL, rd); check("abort_ctrl", rd, 32'd0);
        check("abort_irq", 32'(irq), 32'd0);

        // continuous block of 100..115 averages to 107, accumulator restarted after reset
        for (int i = 0; i < 16; i++) feed_q.push_back(12'(100 + i));
        wb_write(A_CTRL, 32'h1);
        wait_commits(16, 16 * 1000 + 500);
        check("avg_irq_set", 32'(irq), 32'd1);
        wb_read(A_STAT, rd); check("avg_stat", rd, exp_stat(1));
        wb_read(A_AVG, rd);  check("avg_value", rd, 32'd107);
        m_avalid = 0; m_ovr = 0;
        check("avg_irq_clear", 32'(irq), 32'd0);

        // two more blocks with no AVG read -> overrun
        wait_commits(48, 34000);
        wb_read(A_STAT, rd);
        check("ovr_stat", rd, exp_stat(1));
        check("ovr_set", {31'd0, rd[3]}, 32'd1);
        wb_read(A_AVG, rd);  check("ovr_avg_value", rd, {20'd0, m_avg});
        m_avalid = 0; m_ovr = 0;
        wb_read(A_STAT, rd);
        check("ovr_stat_after_read", rd, exp_stat(1));
        check("ovr_avalid_cleared", {30'd0, rd[3:2]}, 32'd0);

        // clearing CONT mid-SHIFT finishes the conversion then idles
        rises = 0;
        wait_rises(4, 2000);
        wb_write(A_CTRL, 32'h0);
        wait_commits(49, 2000);
        repeat (GAP + 200) @(posedge clk);
        #1;
        check("stop_cs_n", 32'(adc_cs_n), 32'd1);
        wb_read(A_CNT, rd);  check("stop_cnt", rd, 32'd49);
        wb_read(A_STAT, rd); check("stop_stat", rd, exp_stat(0));
        wb_read(A_DATA, rd); check("stop_data", rd, {20'd0, m_data});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
